// File: rtl/input_vc_buffer_pkg.sv
// Shared NoC types: flit format, VC FSM states, helpers.
// Imported by the input VC buffer and its FIFO.
package params_noc;

  localparam int VC_NUM    = 4;
  localparam int PORT_NUM  = 5;
  localparam int VC_W      = $clog2(VC_NUM);
  localparam int PORT_W    = $clog2(PORT_NUM);
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    TAIL,
    HEADTAIL
  } flit_type_t;

  typedef logic [PORT_W-1:0] port_t;
  typedef logic [VC_W-1:0]   vc_t;

  typedef struct packed {
    flit_type_t             ftype;
    vc_t                    vc;
    port_t                  out_port;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } vc_state_t;

  function automatic logic is_head(flit_type_t t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

  function automatic logic is_tail(flit_type_t t);
    return (t == TAIL) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-clock per-VC flit FIFO with head-data output.
// Ports: push/pop/din in; full/empty/head out.
module vc_fifo
  import params_noc::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t din,
  output logic  full,
  output logic  empty,
  output flit_t head
);

  localparam int AW = $clog2(DEPTH);

  flit_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/input_vc_buffer.sv
// Router input port: per-VC FIFOs, packet FSMs, allocator requests.
// Ports: flit in, request/out_port to allocator, grant in, flit/credit out, error.
module input_vc_buffer
  import params_noc::flit_t, params_noc::vc_t,
         params_noc::vc_state_t, params_noc::IDLE, params_noc::ACTIVE,
         params_noc::is_head, params_noc::is_tail;
#(
  parameter int VC_NUM    = 4,
  parameter int PORT_NUM  = 5,
  parameter int BUF_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flit_valid_i,
  input  flit_t                                   flit_i,
  output logic [VC_NUM-1:0]                       credit_o,
  output logic [VC_NUM-1:0]                       request_o,
  output logic [VC_NUM-1:0][$clog2(PORT_NUM)-1:0] out_port_o,
  input  logic [VC_NUM-1:0]                       grant_i,
  output logic                                    flit_valid_o,
  output flit_t                                   flit_o,
  output logic                                    error_o
);

  vc_state_t         state_q [VC_NUM];
  flit_t             head    [VC_NUM];
  logic [VC_NUM-1:0] empty;
  logic [VC_NUM-1:0] full;
  logic [VC_NUM-1:0] push;
  logic [VC_NUM-1:0] pop;
  logic [VC_NUM-1:0] discard;
  logic              gnt_onehot;
  logic              gnt_ok;
  logic              gnt_bad;
  logic              drop;
  flit_t             gnt_flit;

  for (genvar g = 0; g < VC_NUM; g++) begin : g_fifo
    vc_fifo #(
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (flit_i),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  always_comb begin
    gnt_onehot = (grant_i != '0) &&
                 ((grant_i & (grant_i - 1'b1)) == '0);
    request_o = '0;
    discard   = '0;
    push      = '0;
    gnt_flit  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      request_o[v] = (state_q[v] == ACTIVE) && !empty[v];
      // a non-head flit at the front of an idle VC has no packet to join
      discard[v]   = (state_q[v] == IDLE) && !empty[v] &&
                     !is_head(head[v].ftype);
      if (grant_i[v]) gnt_flit = head[v];
    end
    gnt_ok  = gnt_onehot && ((grant_i & request_o) != '0);
    gnt_bad = (grant_i != '0) && !gnt_ok;
    pop     = discard | (gnt_ok ? grant_i : '0);
    // a same-cycle pop frees the slot, so a full FIFO can still accept
    for (int v = 0; v < VC_NUM; v++) begin
      push[v] = flit_valid_i && (flit_i.vc == vc_t'(v)) &&
                (!full[v] || pop[v]);
    end
    drop = flit_valid_i && full[flit_i.vc] && !pop[flit_i.vc];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_valid_o <= 1'b0;
      flit_o       <= '0;
      credit_o     <= '0;
      error_o      <= 1'b0;
      out_port_o   <= '0;
      for (int v = 0; v < VC_NUM; v++) state_q[v] <= IDLE;
    end else begin
      flit_valid_o <= gnt_ok;
      if (gnt_ok) flit_o <= gnt_flit;
      credit_o <= pop;
      if (drop || gnt_bad || (discard != '0)) error_o <= 1'b1;
      for (int v = 0; v < VC_NUM; v++) begin
        unique case (state_q[v])
          IDLE: begin
            if (!empty[v] && is_head(head[v].ftype)) begin
              out_port_o[v] <= head[v].out_port;
              state_q[v]    <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (pop[v] && is_tail(head[v].ftype)) state_q[v] <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Randomized + directed bench for input_vc_buffer.
// Queue-based packet model predicts requests, forwards, credits, errors.
module tb_input_vc_buffer;
  import params_noc::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flit_valid_i = 1'b0;
  flit_t                  flit_i = '0;
  logic [3:0]             grant_i = '0;
  logic [3:0]             credit_o;
  logic [3:0]             request_o;
  logic [3:0][PORT_W-1:0] out_port_o;
  logic                   flit_valid_o;
  flit_t                  flit_o;
  logic                   error_o;

  int total = 0;
  int bad   = 0;

  flit_t      q [4][$];
  bit         act [4];
  port_t      port_m [4];
  bit         err_m;
  logic [3:0] exp_credit;
  bit         exp_fv;
  flit_t      exp_flit;

  always #5 clk = ~clk;

  input_vc_buffer #(
    .VC_NUM    (4),
    .PORT_NUM  (5),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_valid_i (flit_valid_i),
    .flit_i       (flit_i),
    .credit_o     (credit_o),
    .request_o    (request_o),
    .out_port_o   (out_port_o),
    .grant_i      (grant_i),
    .flit_valid_o (flit_valid_o),
    .flit_o       (flit_o),
    .error_o      (error_o)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic flit_t mk(flit_type_t t, int vc, int p);
    flit_t f;
    f.ftype    = t;
    f.vc       = vc_t'(vc);
    f.out_port = port_t'(p);
    f.payload  = 16'($urandom);
    return f;
  endfunction

  function automatic logic [3:0] model_req();
    logic [3:0] r;
    r = '0;
    for (int v = 0; v < 4; v++) r[v] = act[v] && (q[v].size() > 0);
    return r;
  endfunction

  // one clock: drive, predict, check after the edge
  task automatic step(bit wv, flit_t f, logic [3:0] g);
    logic [3:0] req;
    bit         legal;
    flit_t      hd;
    flit_valid_i = wv;
    flit_i       = f;
    grant_i      = g;
    req = model_req();
    check("request", 32'(request_o), 32'(req));
    legal = (g != 0) && ($countones(g) == 1) && ((g & req) != 0);
    if (g != 0 && !legal) err_m = 1;
    exp_credit = '0;
    exp_fv     = 0;
    for (int v = 0; v < 4; v++) begin
      if (!act[v]) begin
        if (q[v].size() > 0) begin
          hd = q[v][0];
          if (hd.ftype == HEAD || hd.ftype == HEADTAIL) begin
            act[v]    = 1;
            port_m[v] = hd.out_port;
          end else begin
            void'(q[v].pop_front());
            exp_credit[v] = 1'b1;
            err_m = 1;
          end
        end
      end else if (legal && g[v]) begin
        hd = q[v].pop_front();
        exp_fv        = 1;
        exp_flit      = hd;
        exp_credit[v] = 1'b1;
        if (hd.ftype == TAIL || hd.ftype == HEADTAIL) act[v] = 0;
      end
    end
    if (wv) begin
      if (q[f.vc].size() < DEPTH) q[f.vc].push_back(f);
      else err_m = 1;
    end
    @(posedge clk);
    #1;
    check("flit_valid", 32'(flit_valid_o), 32'(exp_fv));
    if (exp_fv) check("flit", 32'(flit_o), 32'(exp_flit));
    check("credit", 32'(credit_o), 32'(exp_credit));
    check("error", 32'(error_o), 32'(err_m));
    for (int v = 0; v < 4; v++)
      if (act[v]) check("out_port", 32'(out_port_o[v]), 32'(port_m[v]));
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, '0);
  endtask

  // asserted between edges: outputs must clear without a clock
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_request", 32'(request_o), 32'(0));
    check("rst_credit", 32'(credit_o), 32'(0));
    check("rst_out_port", 32'(out_port_o), 32'(0));
    check("rst_flit_valid", 32'(flit_valid_o), 32'(0));
    check("rst_flit", 32'(flit_o), 32'(0));
    check("rst_error", 32'(error_o), 32'(0));
    for (int v = 0; v < 4; v++) begin
      q[v].delete();
      act[v] = 0;
    end
    err_m        = 0;
    flit_valid_i = 1'b0;
    grant_i      = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] req;
    logic [3:0] g;
    int         r;
    int         s;
    bit         wv;
    flit_t      f;

    @(negedge clk);
    do_reset();

    // single-flit packet on vc1
    step(1, mk(HEADTAIL, 1, 3), '0);
    idle(1);
    step(0, '0, 4'b0010);
    idle(2);

    // three-flit packet on vc0, grant held once requesting
    step(1, mk(HEAD, 0, 2), '0);
    step(1, mk(BODY, 0, 2), '0);
    step(1, mk(TAIL, 0, 2), 4'b0001);
    step(0, '0, 4'b0001);
    step(0, '0, 4'b0001);
    idle(2);

    // overflow vc2 without a pop
    step(1, mk(HEAD, 2, 4), '0);
    for (int i = 0; i < 3; i++) step(1, mk(BODY, 2, 0), '0);
    step(1, mk(BODY, 2, 0), '0);
    for (int i = 0; i < 4; i++) step(0, '0, 4'b0100);
    idle(1);

    // full FIFO with a same-cycle pop accepts the write
    do_reset();
    step(1, mk(HEAD, 2, 1), '0);
    for (int i = 0; i < 3; i++) step(1, mk(BODY, 2, 0), '0);
    step(1, mk(TAIL, 2, 0), 4'b0100);
    for (int i = 0; i < 4; i++) step(0, '0, 4'b0100);
    idle(1);

    // orphan body on idle vc3
    do_reset();
    step(1, mk(BODY, 3, 0), '0);
    idle(2);

    // multi-hot grant
    do_reset();
    step(1, mk(HEAD, 0, 1), '0);
    step(1, mk(HEAD, 1, 2), '0);
    idle(1);
    step(0, '0, 4'b0011);
    idle(1);

    // grant to a non-requesting VC
    do_reset();
    step(1, mk(HEAD, 0, 1), '0);
    idle(1);
    step(0, '0, 4'b0100);
    idle(1);

    // reset mid-packet, then a fresh packet
    do_reset();
    step(1, mk(HEAD, 0, 3), '0);
    step(1, mk(BODY, 0, 3), '0);
    step(1, mk(BODY, 0, 3), 4'b0001);
    do_reset();
    step(1, mk(HEAD, 0, 4), '0);
    idle(1);
    step(1, mk(TAIL, 0, 4), 4'b0001);
    step(0, '0, 4'b0001);
    idle(1);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      req = model_req();
      g   = '0;
      r   = $urandom_range(0, 9);
      if (r < 7 && req != 0) begin
        s = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++)
          if (g == 0 && req[(s + k) % 4]) g[(s + k) % 4] = 1'b1;
      end else if (r == 9) begin
        g = 4'($urandom);
      end
      wv = ($urandom_range(0, 1) == 1);
      r  = $urandom_range(0, 9);
      f  = mk(r < 3 ? HEAD : r < 6 ? BODY : r < 8 ? TAIL : HEADTAIL,
              $urandom_range(0, 3), $urandom_range(0, 4));
      step(wv, f, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
